// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard/forwarding controller:
//   - REG_AW      register-address width
//   - SB_DEPTH    number of scoreboard stages (EX, MEM, WB); fixed at 3
//   - fwd_sel_e   EX operand-mux select encoding
//   - sb_entry_t  scoreboard entry layout {valid, wR, is_load} and bit offsets
//   - helper functions to build an entry, match a source register against a
//     stage, and resolve the forwarding priority.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int SB_DEPTH = 3;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_e;

  // Scoreboard entry layout, MSB to LSB: valid | wR | is_load
  localparam int SB_LOAD_BIT  = 0;
  localparam int SB_WR_LSB    = 1;
  localparam int SB_WR_MSB    = REG_AW;
  localparam int SB_VALID_BIT = REG_AW + 1;
  localparam int SB_W         = REG_AW + 2;

  typedef logic [SB_W-1:0] sb_entry_t;

  // Assemble a scoreboard entry from its fields.
  function automatic sb_entry_t sb_pack(input logic              valid,
                                        input logic [REG_AW-1:0] wr,
                                        input logic              is_load);
    return {valid, wr, is_load};
  endfunction

  // A source register depends on a stage only if it is actually read, is not
  // x0, and the stage holds a valid writer of that same register.
  function automatic logic sb_match(input logic              used,
                                    input logic [REG_AW-1:0] rs,
                                    input logic              valid,
                                    input logic [REG_AW-1:0] wr);
    return used && (rs != {REG_AW{1'b0}}) && valid && (wr == rs);
  endfunction

  // Youngest producer wins: EX (ALU result only) > MEM > WB > register file.
  function automatic fwd_sel_e fwd_pick(input logic ex_alu_hit,
                                        input logic mem_hit,
                                        input logic wb_hit);
    fwd_sel_e sel;
    if (ex_alu_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// -----------------------------------------------------------------------------
// hazard_sb_stage
// One scoreboard entry register {valid, wR, is_load}.
// Ports:
//   clk, rst  clock; asynchronous active-high clear (entry becomes invalid)
//   load_i    capture d_i this cycle
//   inv_i     capture d_i but force the valid bit low (bubble); wins over load_i
//   d_i       incoming entry
//   q_o       registered entry
// -----------------------------------------------------------------------------
module hazard_sb_stage
  import hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  logic      inv_i,
  input  sb_entry_t d_i,
  output sb_entry_t q_o
);

  sb_entry_t entry_q;
  sb_entry_t entry_d;

  // Next-state selection: bubble, load or hold.
  always_comb begin
    entry_d = entry_q;
    if (inv_i) begin
      entry_d               = d_i;
      entry_d[SB_VALID_BIT] = 1'b0;
    end else if (load_i) begin
      entry_d = d_i;
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= {SB_W{1'b0}};
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard/forwarding controller for the 5-stage pipeline. Tracks the
// destination registers of the instructions in EX, MEM and WB in a 3-entry
// shifting scoreboard and derives, combinationally from it and the ID-stage
// instruction:
//   - load-use stalls (hold PC and IF/ID, bubble ID/EX for one cycle)
//   - taken-branch/jump flushes (clear IF/ID and ID/EX)
//   - EX operand forwarding selects.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   id_rs1, id_rs2           ID source registers
//   id_rs1_used, id_rs2_used ID instruction reads rs1 / rs2
//   id_wR, id_rf_we          ID destination register and its write enable
//   id_is_load               ID instruction's write data comes from DRAM
//   ex_redirect              EX resolved a taken branch/jump
//   stall_pc, stall_ifid     hold PC / IF/ID
//   flush_ifid, flush_idex   clear IF/ID / ID/EX to a bubble
//   fwd_a_sel, fwd_b_sel     EX operand sources (hazard_ctrl_pkg::fwd_sel_e)
//
// Configuration macro HAZARD_PERF_EN: when defined, adds
//   perf_stall_cnt[31:0]     load-use stall cycles (wrapping)
//   perf_flush_cnt[31:0]     ex_redirect cycles (wrapping)
// Register width and scoreboard depth come from hazard_ctrl_pkg
// (REG_AW = 5, SB_DEPTH = 3; only depth 3 is supported).
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_wR,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  sb_entry_t push_d;
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;

  logic push_valid_s;
  logic ex_hit_a_s;
  logic ex_hit_b_s;
  logic mem_hit_a_s;
  logic mem_hit_b_s;
  logic wb_hit_a_s;
  logic wb_hit_b_s;
  logic lu_rs1_s;
  logic lu_rs2_s;
  logic load_use_s;
  logic lu_stall_s;
  logic ex_inv_s;
  logic unused_wb_load_s;

  // x0 writes never enter the scoreboard as valid entries.
  assign push_valid_s = id_rf_we && (id_wR != {REG_AW{1'b0}});
  assign push_d       = sb_pack(push_valid_s, id_wR, id_is_load);

  assign ex_hit_a_s  = sb_match(id_rs1_used, id_rs1, ex_q[SB_VALID_BIT],  ex_q[SB_WR_MSB:SB_WR_LSB]);
  assign ex_hit_b_s  = sb_match(id_rs2_used, id_rs2, ex_q[SB_VALID_BIT],  ex_q[SB_WR_MSB:SB_WR_LSB]);
  assign mem_hit_a_s = sb_match(id_rs1_used, id_rs1, mem_q[SB_VALID_BIT], mem_q[SB_WR_MSB:SB_WR_LSB]);
  assign mem_hit_b_s = sb_match(id_rs2_used, id_rs2, mem_q[SB_VALID_BIT], mem_q[SB_WR_MSB:SB_WR_LSB]);
  assign wb_hit_a_s  = sb_match(id_rs1_used, id_rs1, wb_q[SB_VALID_BIT],  wb_q[SB_WR_MSB:SB_WR_LSB]);
  assign wb_hit_b_s  = sb_match(id_rs2_used, id_rs2, wb_q[SB_VALID_BIT],  wb_q[SB_WR_MSB:SB_WR_LSB]);

  // A load in EX cannot be forwarded yet; one dependent operand is enough
  // for a single one-cycle stall, even if both operands depend on it.
  assign lu_rs1_s   = ex_hit_a_s && ex_q[SB_LOAD_BIT];
  assign lu_rs2_s   = ex_hit_b_s && ex_q[SB_LOAD_BIT];
  assign load_use_s = lu_rs1_s || lu_rs2_s;

  // A redirect squashes the ID instruction, so a pending stall is moot.
  assign lu_stall_s = load_use_s && !ex_redirect;

  // The ID instruction does not advance into EX when it is stalled or
  // squashed; a bubble enters the scoreboard instead.
  assign ex_inv_s = load_use_s || ex_redirect;

  // The WB entry's load flag has no consumer; WB data is already resolved.
  assign unused_wb_load_s = wb_q[SB_LOAD_BIT];

  hazard_sb_stage u_sb_ex (
    .clk    (clk),
    .rst    (rst),
    .load_i (1'b1),
    .inv_i  (ex_inv_s),
    .d_i    (push_d),
    .q_o    (ex_q)
  );

  hazard_sb_stage u_sb_mem (
    .clk    (clk),
    .rst    (rst),
    .load_i (1'b1),
    .inv_i  (1'b0),
    .d_i    (ex_q),
    .q_o    (mem_q)
  );

  hazard_sb_stage u_sb_wb (
    .clk    (clk),
    .rst    (rst),
    .load_i (1'b1),
    .inv_i  (1'b0),
    .d_i    (mem_q),
    .q_o    (wb_q)
  );

  // Stall/flush/forward outputs; everything is held at zero while in reset.
  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    fwd_a_sel  = FWD_RF;
    fwd_b_sel  = FWD_RF;
    if (rst) begin
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      fwd_a_sel  = FWD_RF;
      fwd_b_sel  = FWD_RF;
    end else begin
      if (ex_redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (lu_stall_s) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end else begin
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
      end
      // A load hit in EX is the stall case, so it drops to lower priority.
      fwd_a_sel = fwd_pick(ex_hit_a_s && !ex_q[SB_LOAD_BIT], mem_hit_a_s, wb_hit_a_s);
      fwd_b_sel = fwd_pick(ex_hit_b_s && !ex_q[SB_LOAD_BIT], mem_hit_b_s, wb_hit_b_s);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_stall_d;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_flush_d;

  // Performance counter next-state; both wrap naturally at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (lu_stall_s) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (ex_redirect) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
  end

  // Performance counter registers, cleared and held at zero by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Table-driven bench for hazard_ctrl. Each row is one ID-stage cycle: the
// inputs are driven after the falling edge, the expected outputs are queued,
// and the outputs are popped and compared 1 time unit later, well away from
// the rising edge. The rows are ordered so that the scoreboard contents
// implied by earlier rows give the expected forwarding/stall values.
// A hand-written sequence then covers asynchronous reset during a stall.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_wR;
  logic       id_rf_we;
  logic       id_is_load;
  logic       ex_redirect;
  logic       stall_pc;
  logic       stall_ifid;
  logic       flush_ifid;
  logic       flush_idex;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  int total;
  int bad;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] wr;
    logic       we;
    logic       ld;
    logic       rd;
    logic [3:0] exp_ctl;  // {stall_pc, stall_ifid, flush_ifid, flush_idex}
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_wR       (id_wR),
    .id_rf_we    (id_rf_we),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input int rs1, input int u1,
                              input int rs2, input int u2, input int wr,
                              input int we, input int ld, input int rd,
                              input logic [3:0] ctl, input int fa, input int fb);
    vec_t v;
    v.name    = n;
    v.rs1     = rs1[4:0];
    v.u1      = u1[0];
    v.rs2     = rs2[4:0];
    v.u2      = u2[0];
    v.wr      = wr[4:0];
    v.we      = we[0];
    v.ld      = ld[0];
    v.rd      = rd[0];
    v.exp_ctl = ctl;
    v.exp_fa  = fa[1:0];
    v.exp_fb  = fb[1:0];
    return v;
  endfunction

  task automatic cmp(input string n, input string sig, input logic [1:0] act,
                     input logic [1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s.%s: got %0b expected %0b", n, sig, act, exp);
    end
  endtask

  // Drive a row's inputs and queue its expected outputs.
  task automatic drive_row(input vec_t v);
    id_rs1      = v.rs1;
    id_rs1_used = v.u1;
    id_rs2      = v.rs2;
    id_rs2_used = v.u2;
    id_wR       = v.wr;
    id_rf_we    = v.we;
    id_is_load  = v.ld;
    ex_redirect = v.rd;
    exp_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare the current outputs against it.
  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      cmp(e.name, "stall_pc",   {1'b0, stall_pc},   {1'b0, e.exp_ctl[3]});
      cmp(e.name, "stall_ifid", {1'b0, stall_ifid}, {1'b0, e.exp_ctl[2]});
      cmp(e.name, "flush_ifid", {1'b0, flush_ifid}, {1'b0, e.exp_ctl[1]});
      cmp(e.name, "flush_idex", {1'b0, flush_idex}, {1'b0, e.exp_ctl[0]});
      cmp(e.name, "fwd_a_sel",  fwd_a_sel,          e.exp_fa);
      cmp(e.name, "fwd_b_sel",  fwd_b_sel,          e.exp_fb);
    end
  endtask

  task automatic check_now(input vec_t v);
    drive_row(v);
    #1;
    check_out();
  endtask

  task automatic run_row(input vec_t v);
    @(negedge clk);
    check_now(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //               name            rs1 u1 rs2 u2  wR we ld rd  ctl      fa fb
    vecs.push_back(mk("idle",          0, 0,  0, 0,  0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("alu_add_x5",    1, 1,  2, 1,  5, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("ex_fwd_a",      5, 1,  5, 0,  0, 0, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk("mem_fwd",       5, 1,  5, 1,  0, 0, 0, 0, 4'b0000, 2, 2));
    vecs.push_back(mk("wb_fwd",        5, 1,  0, 0,  0, 0, 0, 0, 4'b0000, 3, 0));
    vecs.push_back(mk("fwd_gone",      5, 1,  5, 1,  0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("lw_x6",         1, 1,  0, 0,  6, 1, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("lu_rs2",        0, 0,  6, 1,  7, 1, 0, 0, 4'b1101, 0, 0));
    vecs.push_back(mk("lu_release",    0, 0,  6, 1,  7, 1, 0, 0, 4'b0000, 0, 2));
    vecs.push_back(mk("after_lu",      7, 1,  6, 1,  0, 0, 0, 0, 4'b0000, 1, 3));
    vecs.push_back(mk("x0_alu",        0, 1,  0, 0,  0, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("x0_load",       0, 1,  0, 1,  0, 1, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("x0_read",       0, 1,  0, 1,  0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("lw_x8",         0, 0,  0, 0,  8, 1, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("redir_lu",      8, 1,  0, 0,  9, 1, 0, 1, 4'b0011, 0, 0));
    vecs.push_back(mk("post_redir",    9, 1,  8, 1,  0, 0, 0, 0, 4'b0000, 0, 2));
    vecs.push_back(mk("add_x7_a",      0, 0,  0, 0,  7, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("add_x7_b",      0, 0,  0, 0,  7, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("add_x7_c",      0, 0,  0, 0,  7, 1, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("prio_ex",       7, 1,  7, 1,  0, 0, 0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk("prio_mem",      7, 1,  7, 1,  0, 0, 0, 0, 4'b0000, 2, 2));
    vecs.push_back(mk("prio_wb",       7, 1,  7, 1,  0, 0, 0, 0, 4'b0000, 3, 3));
    vecs.push_back(mk("prio_none",     7, 1,  7, 1,  0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("lw_x10",        0, 0,  0, 0, 10, 1, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("lw_x11_lu",    10, 1,  0, 0, 11, 1, 1, 0, 4'b1101, 0, 0));
    vecs.push_back(mk("lw_x11_held",  10, 1,  0, 0, 11, 1, 1, 0, 4'b0000, 2, 0));
    vecs.push_back(mk("dual_lu",      11, 1, 11, 1, 12, 1, 0, 0, 4'b1101, 0, 0));
    vecs.push_back(mk("dual_held",    11, 1, 11, 1, 12, 1, 0, 0, 4'b0000, 2, 2));
    vecs.push_back(mk("idle_end",      0, 0,  0, 0,  0, 0, 0, 0, 4'b0000, 0, 0));

    // Reset state: outputs forced low even with redirect and a read pending.
    rst = 1'b1;
    #2;
    check_now(mk("reset_state", 5, 1, 5, 1, 5, 1, 1, 1, 4'b0000, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i]);
    end

    // Asynchronous reset in the middle of a load-use stall.
    run_row(mk("rst_lw_x13",         0, 0, 0, 0, 13, 1, 1, 0, 4'b0000, 0, 0));
    run_row(mk("rst_pre_stall",     13, 1, 0, 0,  0, 0, 0, 0, 4'b1101, 0, 0));
    rst = 1'b1;
    check_now(mk("rst_mid_stall",   13, 1, 0, 0,  0, 0, 0, 1, 4'b0000, 0, 0));
    run_row(mk("rst_held",          13, 1, 13, 1, 13, 1, 0, 1, 4'b0000, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    check_now(mk("post_rst_empty",  13, 1, 0, 0, 13, 1, 0, 0, 4'b0000, 0, 0));
    run_row(mk("post_rst_writer",   13, 1, 13, 1, 0, 0, 0, 0, 4'b0000, 1, 1));

    if (exp_q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard/forwarding controller for the 5-stage pipeline. It sequences the IF/ID and ID/EX pipeline registers and the PC register.
- Keeps a 3-deep scoreboard (EX, MEM, WB) of in-flight destination registers, shifted every cycle.
- From the scoreboard it derives load-use stalls, ID/EX bubble insertion, taken-branch flushes and operand forwarding selects.
- Sits beside the ID stage; its outputs drive the pipeline-register stall/flush inputs and the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width.
- SB_DEPTH, 3, scoreboard depth (EX, MEM, WB); fixed at 3, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_rs1  in  REG_AW  source register 1 of the instruction in ID
- id_rs2  in  REG_AW  source register 2 of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- id_wR  in  REG_AW  destination register of the ID instruction
- id_rf_we  in  1  ID instruction writes the RF
- id_is_load  in  1  ID instruction's RF write data comes from DRAM
- ex_redirect  in  1  EX resolved a taken branch or jump (npc != pc4)
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID
- flush_ifid  out  1  clear IF/ID to NOP
- flush_idex  out  1  clear ID/EX to bubble (rf_we=0, dram_we=0)
- fwd_a_sel  out  2  EX operand A source: 00 RF, 01 EX/MEM ALU, 10 MEM/WB, 11 WB write-back
- fwd_b_sel  out  2  same encoding for operand B

Behaviour:
- Scoreboard entry fields: valid, wR, is_load. Entry is valid only if rf_we=1 and wR!=0; x0 never creates a hazard.
- Every posedge: WB<=MEM, MEM<=EX, EX<=push.
- push = {id_rf_we && id_wR!=0, id_wR, id_is_load}, except push is invalid when the load-use stall is active or ex_redirect=1.
- match(rs, stage) = rs_used && rs!=0 && stage.valid && stage.wR==rs.
- Load-use: match(rs1 or rs2, EX) with EX.is_load=1 gives stall_pc=1, stall_ifid=1, flush_idex=1 for exactly 1 cycle. Next cycle the load sits in MEM and is forwarded from MEM/WB.
- Redirect: ex_redirect=1 gives flush_ifid=1 and flush_idex=1, stall_pc=0, stall_ifid=0. Redirect overrides load-use, since the stalled instruction is on the wrong path.
- Forwarding is combinational from the registered scoreboard, priority EX > MEM > WB > RF. The EX match uses code 01 only when EX.is_load=0; a load match in EX is the stall case and leaves the select at the lower-priority result.
- Stall and forwarding outputs are combinational; there is zero added latency.
- Simultaneous load-use on rs1 and rs2 still produces a single 1-cycle stall.
- Back-to-back loads are each checked independently.
- Reset: scoreboard valids cleared. While rst=1 every output is forced to 0, including when ex_redirect=1.
- Reset mid-stall: the stall ends immediately; no residual bubble after reset is released.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments once per load-use stall cycle.
  - perf_flush_cnt increments once per ex_redirect cycle.
  - Both wrap at 2^32, are cleared by rst and hold at 0 during reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines.vh: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WB=2'b11, and REG_AW.
- Scoreboard entry width/field offsets (valid, wR, is_load) also go in the package.
- One natural sub-module: hazard_sb_stage, a single scoreboard entry register with async clear and load/invalidate. Instantiate it 3 times.
- Match and priority logic stays in hazard_ctrl.

Test Plan:
- Back-to-back ALU dependency: add x5 (ID, then EX); next ID instruction reads rs1=x5 → fwd_a_sel=01, no stall, all flush outputs 0.
- Load-use: lw x6 in EX; ID reads rs2=x6 → stall_pc=stall_ifid=flush_idex=1 for 1 cycle. Next cycle fwd_b_sel=10 and stall=0.
- x0 destination: EX holds a write to x0; ID reads rs1=x0 → fwd_a_sel=00, no stall.
- Redirect during load-use: ex_redirect=1 together with a load-use match → flush_ifid=flush_idex=1, stall_pc=0. Next cycle the EX entry is invalid.
- Priority: x7 valid in both EX (ALU) and WB; ID reads x7 on rs1 and rs2 → fwd_a_sel=fwd_b_sel=01.
- Async reset asserted mid-stall: all outputs 0 within the same cycle. After release, the scoreboard is empty and no forwarding occurs until a new writer passes through.
